// File: rtl/axi_stream_slave.sv
// -----------------------------------------------------------------------------
// axi_stream_slave
//   Receives a byte-serial AXI-stream (data/valid/last with ready back-pressure)
//   and packs the bytes of one frame into an N_BYTES-wide word, first byte in
//   the least significant lane. A finished word is held for a parallel consumer
//   until it is read with re. While a word is held, ready stays low.
//
//   A frame that reaches N_BYTES bytes without last is closed as a full word
//   with err=1 (overrun). The bytes that follow start a fresh word.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   reset      in   asynchronous, active-high reset
//   data       in   [7:0]           stream byte from the master
//   valid      in                   master presents a byte on data
//   last       in                   byte on data closes the frame
//   ready      out                  slave can accept a beat (registered)
//   data_out   out  [8*N_BYTES-1:0] assembled word, byte k at [8k+7:8k]
//   out_valid  out                  data_out holds a complete word (registered)
//   byte_cnt   out  [CNT_W-1:0]     bytes in the held word, 1..N_BYTES
//   err        out                  overrun flag for the held word
//   re         in                   consumer read strobe
// -----------------------------------------------------------------------------
module axi_stream_slave #(
  parameter  int N_BYTES = 8,
  localparam int CNT_W   = $clog2(N_BYTES + 1),
  localparam int W       = 8 * N_BYTES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       data,
  input  logic             valid,
  input  logic             last,
  output logic             ready,
  output logic [W-1:0]     data_out,
  output logic             out_valid,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             err,
  input  logic             re
);

  typedef enum logic {
    S_RECV,
    S_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);

  state_t           r_state;
  logic             r_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_idx;
  logic [W-1:0]     r_word;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  state_t           w_state_nx;
  logic             w_ready_nx;
  logic             w_out_valid_nx;
  logic [CNT_W-1:0] w_idx_nx;
  logic [W-1:0]     w_word_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_err_nx;

  // The only transfer condition: a beat moves when both sides agree.
  logic w_xfer;
  assign w_xfer = valid & r_ready;

  // NOTE: every signal driven here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nx     = r_state;
    w_ready_nx     = r_ready;
    w_out_valid_nx = r_out_valid;
    w_idx_nx       = r_idx;
    w_word_nx      = r_word;
    w_cnt_nx       = r_cnt;
    w_err_nx       = r_err;

    case (r_state)
      S_RECV: begin
        // ready is low only in the first cycle after reset; raise it here.
        w_ready_nx = 1'b1;
        if (w_xfer) begin
          for (int k = 0; k < N_BYTES; k++) begin
            if (r_idx == CNT_W'(k)) w_word_nx[8*k +: 8] = data;
          end
          if (last || (r_idx == LAST_IDX)) begin
            // Frame closes: either by last, or by filling the final lane
            // without last, which is an overrun.
            w_state_nx     = S_HOLD;
            w_out_valid_nx = 1'b1;
            w_ready_nx     = 1'b0;
            w_idx_nx       = '0;
            w_cnt_nx       = r_idx + 1'b1;
            w_err_nx       = ~last;
          end else begin
            w_idx_nx = r_idx + 1'b1;
          end
        end
      end

      S_HOLD: begin
        // Clearing the word on read means unwritten lanes of the next
        // (possibly short) frame read back as zero.
        if (re) begin
          w_state_nx     = S_RECV;
          w_out_valid_nx = 1'b0;
          w_ready_nx     = 1'b1;
          w_word_nx      = '0;
          w_cnt_nx       = '0;
          w_err_nx       = 1'b0;
        end
      end

      default: begin
        w_state_nx = S_RECV;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_RECV;
      r_ready     <= 1'b0;
      r_out_valid <= 1'b0;
      r_idx       <= '0;
      r_word      <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_ready     <= w_ready_nx;
      r_out_valid <= w_out_valid_nx;
      r_idx       <= w_idx_nx;
      r_word      <= w_word_nx;
      r_cnt       <= w_cnt_nx;
      r_err       <= w_err_nx;
    end
  end

  assign ready     = r_ready;
  assign out_valid = r_out_valid;
  assign data_out  = r_word;
  assign byte_cnt  = r_cnt;
  assign err       = r_err;

endmodule

// File: tb/tb_axi_stream_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_slave
//   Directed and randomized stimulus for axi_stream_slave. A frame-level model
//   (a byte queue plus a "word held" flag) predicts ready, out_valid and the
//   held word; DUT outputs are compared 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_axi_stream_slave;

  localparam int N_BYTES = 8;
  localparam int W       = 8 * N_BYTES;

  logic         clk;
  logic         reset;
  logic [7:0]   data;
  logic         valid;
  logic         last;
  logic         ready;
  logic [W-1:0] data_out;
  logic         out_valid;
  logic [3:0]   byte_cnt;
  logic         err;
  logic         re;

  int n_checks;
  int n_errors;

  // Reference model state
  logic [7:0]   m_q[$];
  bit           m_held;
  bit           m_ready;
  logic [W-1:0] m_word;
  int           m_cnt;
  bit           m_err;
  int           m_words;

  axi_stream_slave #(.N_BYTES(N_BYTES)) dut (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .valid     (valid),
    .last      (last),
    .ready     (ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .byte_cnt  (byte_cnt),
    .err       (err),
    .re        (re)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_held  = 1'b0;
    m_ready = 1'b0;
    m_word  = '0;
    m_cnt   = 0;
    m_err   = 1'b0;
  endtask

  // One rising edge as seen at frame level.
  task automatic model_edge(input logic [7:0] d, input bit v, input bit l, input bit r);
    if (m_held) begin
      if (r) begin
        m_held  = 1'b0;
        m_ready = 1'b1;
        m_word  = '0;
        m_cnt   = 0;
        m_err   = 1'b0;
      end
    end else if (v && m_ready) begin
      m_q.push_back(d);
      if (l || m_q.size() == N_BYTES) begin
        m_word = '0;
        foreach (m_q[i]) m_word[8*i +: 8] = m_q[i];
        m_cnt   = m_q.size();
        m_err   = !l;
        m_held  = 1'b1;
        m_ready = 1'b0;
        m_words++;
        m_q.delete();
      end
    end else begin
      m_ready = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".ready"},     W'(ready),     W'(m_ready));
    check({tag, ".out_valid"}, W'(out_valid), W'(m_held));
    check({tag, ".byte_cnt"},  W'(byte_cnt),  W'(m_cnt));
    check({tag, ".err"},       W'(err),       W'(m_err));
    if (m_held) check({tag, ".data_out"}, data_out, m_word);
  endtask

  // Drive one cycle of inputs, clock it, update the model, compare.
  task automatic cycle(input string tag, input logic [7:0] d, input bit v, input bit l, input bit r);
    data  = d;
    valid = v;
    last  = l;
    re    = r;
    @(posedge clk);
    model_edge(d, v, l, r);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    model_reset();
    #1;
    check("rst.async.data_out", data_out, '0);
    check_outputs("rst.async");
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("rst.data_out", data_out, '0);
      check_outputs("rst");
    end
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] bytes_a[8];
    n_checks = 0;
    n_errors = 0;
    m_words  = 0;
    data = '0; valid = 0; last = 0; re = 0; reset = 0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset state, then ready rises one edge after release
    apply_reset(2);
    idle("post_rst", 1);
    check("post_rst.ready_is_1", W'(ready), W'(1'b1));

    // Full frame 01..08, valid held high
    for (int i = 0; i < 8; i++) cycle("full", 8'(i + 1), 1'b1, i == 7, 1'b0);
    check("full.word", data_out, 64'h0807060504030201);
    idle("full.hold", 2);
    cycle("full.read", 8'h00, 1'b0, 1'b0, 1'b1);

    // Gapped valid: 3 idle cycles after byte 03
    for (int i = 0; i < 3; i++) cycle("gap", 8'(i + 1), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("gap.idle", 8'hEE, 1'b0, 1'b1, 1'b0);
    for (int i = 3; i < 8; i++) cycle("gap", 8'(i + 1), 1'b1, i == 7, 1'b0);
    check("gap.word", data_out, 64'h0807060504030201);
    cycle("gap.read", 8'h00, 1'b0, 1'b0, 1'b1);

    // Short frame A1 B2 C3
    bytes_a = '{8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) cycle("short", bytes_a[i], 1'b1, i == 2, 1'b0);
    check("short.word", data_out, 64'h0000000000C3B2A1);
    check("short.cnt", W'(byte_cnt), W'(3));

    // Hold: 55 presented for 4 clk is not accepted; re releases; 55 lands in lane 0
    for (int i = 0; i < 4; i++) cycle("hold.bp", 8'h55, 1'b1, 1'b1, 1'b0);
    check("hold.unchanged", data_out, 64'h0000000000C3B2A1);
    cycle("hold.read", 8'h55, 1'b1, 1'b1, 1'b1);
    check("hold.ready_after_re", W'(ready), W'(1'b1));
    check("hold.ov_after_re", W'(out_valid), W'(1'b0));
    cycle("hold.capture", 8'h55, 1'b1, 1'b1, 1'b0);
    check("hold.lane0", data_out, 64'h0000000000000055);
    cycle("hold.read2", 8'h00, 1'b0, 1'b0, 1'b1);

    // Overrun: 01..08 without last, then 09 with last
    for (int i = 0; i < 8; i++) cycle("ovr", 8'(i + 1), 1'b1, 1'b0, 1'b0);
    check("ovr.word", data_out, 64'h0807060504030201);
    check("ovr.err", W'(err), W'(1'b1));
    check("ovr.cnt", W'(byte_cnt), W'(8));
    cycle("ovr.read", 8'h09, 1'b1, 1'b1, 1'b1);
    cycle("ovr.next", 8'h09, 1'b1, 1'b1, 1'b0);
    check("ovr.word2", data_out, 64'h0000000000000009);
    check("ovr.err2", W'(err), W'(1'b0));
    check("ovr.cnt2", W'(byte_cnt), W'(1));
    cycle("ovr.read2", 8'h00, 1'b0, 1'b0, 1'b1);

    // Reset mid-frame discards the partial word
    for (int i = 0; i < 3; i++) cycle("mid", 8'hF0 + 8'(i), 1'b1, 1'b0, 1'b0);
    apply_reset(2);
    cycle("mid.release", 8'h11, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle("mid.frame", 8'h11 + 8'(i), 1'b1, i == 7, 1'b0);
    check("mid.word", data_out, 64'h1817161514131211);
    cycle("mid.read", 8'h00, 1'b0, 1'b0, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle("rand",
            8'($urandom_range(0, 255)),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) == 0);
    end
    check("rand.words_seen", W'(m_words > 20), W'(1'b1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
